// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: accepts a word on valid/ready, emits a one-cycle
// frame clear followed by the word LSB-first, one bit per clock.
`timescale 1ns/1ps

module serial_word_feeder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             t_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_clr,
    output logic             last_bit,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SHIFT
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    idx, idx_nxt;
    logic             at_last;
    logic             accept;

    // in_ready is decoded from state/idx only, so accept has no path to outputs
    assign at_last = (state == SHIFT) && (idx == CW'(WIDTH - 1));
    assign accept  = in_valid && in_ready;

    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (accept) begin
                    shreg_nxt = in_data;
                    idx_nxt   = '0;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                state_nxt = SHIFT;
            end
            SHIFT: begin
                shreg_nxt = shreg >> 1;
                idx_nxt   = idx + CW'(1);
                if (at_last) begin
                    if (accept) begin
                        shreg_nxt = in_data;
                        idx_nxt   = '0;
                        state_nxt = CLEAR;
                    end else begin
                        idx_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        bit_out   = 1'b0;
        bit_valid = 1'b0;
        frame_clr = 1'b0;
        last_bit  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            CLEAR: begin
                frame_clr = 1'b1;
            end
            SHIFT: begin
                bit_valid = 1'b1;
                bit_out   = shreg[0];
                last_bit  = at_last;
                in_ready  = at_last;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: directed and random steps checked against a
// queue of expected per-cycle output tuples.
`timescale 1ns/1ps

module tb_serial_word_feeder;

    localparam int unsigned WIDTH = 8;

    logic             t_clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready, bit_out, bit_valid, frame_clr, last_bit, busy;

    serial_word_feeder #(.WIDTH(WIDTH)) dut (
        .t_clk     (t_clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .frame_clr (frame_clr),
        .last_bit  (last_bit),
        .busy      (busy)
    );

    always #5 t_clk = ~t_clk;

    typedef struct packed {
        logic clr;
        logic vld;
        logic dat;
        logic lst;
    } cyc_t;

    cyc_t       exp_q[$];
    int         passed = 0;
    int         total  = 0;
    logic       cap_bits[$];
    logic [7:0] cap_word;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    endtask

    // Expected output for one accepted word: a clear cycle then WIDTH bits LSB-first.
    task automatic push_frame(input logic [WIDTH-1:0] d);
        cyc_t c;
        c = '{clr: 1'b1, vld: 1'b0, dat: 1'b0, lst: 1'b0};
        exp_q.push_back(c);
        for (int k = 0; k < int'(WIDTH); k++) begin
            c = '{clr: 1'b0, vld: 1'b1, dat: d[k], lst: (k == int'(WIDTH) - 1)};
            exp_q.push_back(c);
        end
    endtask

    // One clock cycle: check outputs mid-cycle, drive inputs, advance the model at the edge.
    task automatic step(input logic v, input logic [WIDTH-1:0] d);
        cyc_t cur;
        logic model_ready;
        @(negedge t_clk);
        cur = (exp_q.size() > 0) ? exp_q[0] : cyc_t'(4'b0000);
        model_ready = (exp_q.size() <= 1);
        check("frame_clr", 32'(frame_clr), 32'(cur.clr));
        check("bit_valid", 32'(bit_valid), 32'(cur.vld));
        check("bit_out",   32'(bit_out),   32'(cur.dat));
        check("last_bit",  32'(last_bit),  32'(cur.lst));
        check("busy",      32'(busy),      32'(exp_q.size() > 0));
        if (rst_n) check("in_ready", 32'(in_ready), 32'(model_ready));
        if (cur.clr) cap_bits.delete();
        if (cur.vld) cap_bits.push_back(bit_out);
        in_valid = v;
        in_data  = d;
        @(posedge t_clk);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (rst_n && v && model_ready) push_frame(d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, WIDTH'($urandom));
    endtask

    initial begin
        logic seen;
        logic [7:0] comp;

        // Reset held with a valid word presented: nothing may be accepted.
        for (int i = 0; i < 3; i++) step(1'b1, 8'hFF);
        #2 rst_n = 1'b1;

        // Single word; also feeds the end-to-end complement check.
        step(1'b1, 8'b0000_0110);
        idle(WIDTH + 2);
        cap_word = '0;
        for (int k = 0; k < cap_bits.size() && k < 8; k++) cap_word[k] = cap_bits[k];
        check("capture_06", 32'(cap_word), 32'h06);
        seen = 1'b0;
        comp = '0;
        for (int k = 0; k < 8; k++) begin
            comp[k] = seen ? ~cap_word[k] : cap_word[k];
            if (cap_word[k]) seen = 1'b1;
        end
        check("complement_06", 32'(comp), 32'(8'(0 - 8'h06)));

        // Back-to-back: 8'h80 held valid throughout, taken only at the last bit.
        step(1'b1, 8'h01);
        for (int i = 0; i < int'(WIDTH) + 1; i++) step(1'b1, 8'h80);
        idle(WIDTH + 2);

        // Valid pulse at idx=3 must be ignored.
        step(1'b1, 8'h0F);
        idle(4);
        step(1'b1, 8'hAA);
        idle(WIDTH);

        // Asynchronous reset after bit 4 of 8'hC3.
        step(1'b1, 8'hC3);
        idle(6);
        #3 rst_n = 1'b0;
        #1;
        check("async_bit_valid", 32'(bit_valid), 32'h0);
        check("async_busy",      32'(busy),      32'h0);
        check("async_frame_clr", 32'(frame_clr), 32'h0);
        exp_q.delete();
        step(1'b1, 8'hFF);
        step(1'b0, 8'h00);
        #2 rst_n = 1'b1;
        step(1'b1, 8'h05);
        idle(WIDTH + 2);

        // Random traffic.
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 2) != 0), WIDTH'($urandom));
        idle(WIDTH + 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
